// File: rtl/sonuc_toplayici.sv
// sonuc_toplayici: sink for the 24-bit result stream; buffers pixels and sends each as R,G,B bytes.
// Optional header bytes ahead of the pixel data are built in when SONUC_BASLIK_EN is defined.
module sonuc_toplayici #(
    parameter int DERINLIK = 8,
    parameter int SAYAC_W  = 17
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               basla_i,
    input  logic [SAYAC_W-1:0] hedef_i,
    input  logic               etkin_i,
    input  logic [23:0]        pixel_i,
    output logic               stal_o,
    output logic [7:0]         bayt_o,
    output logic               bayt_gecerli_o,
    input  logic               bayt_hazir_i,
    output logic               mesgul_o,
    output logic               bitti_o,
    output logic               hata_o,
    output logic [SAYAC_W-1:0] sayac_o
);
    localparam int AW = $clog2(DERINLIK);
    localparam logic [AW:0]         DOLU  = (AW+1)'(DERINLIK);
    localparam logic [AW:0]         BIR_S = (AW+1)'(1);
    localparam logic [AW-1:0]       BIR_P = AW'(1);
    localparam logic [SAYAC_W-1:0]  BIR_C = SAYAC_W'(1);

`ifdef SONUC_BASLIK_EN
    typedef enum logic [1:0] {BOSTA = 2'd0, BASLIK = 2'd1, VERI = 2'd2} durum_t;

    function automatic logic [7:0] baslik_bayti(input logic [2:0] idx, input logic [23:0] h);
        logic [7:0] b;
        case (idx)
            3'd0:    b = 8'hA5;
            3'd1:    b = {7'b0000000, h[16]};
            3'd2:    b = h[15:8];
            default: b = h[7:0];
        endcase
        return b;
    endfunction
`else
    typedef enum logic [1:0] {BOSTA = 2'd0, VERI = 2'd2} durum_t;
`endif

    durum_t              durum_q, durum_d;
    logic [SAYAC_W-1:0]  hedef_q, hedef_d, kabul_q, kabul_d, sayac_q, sayac_d;
    logic                hata_q, hata_d, bitti_q, bitti_d;
    logic [23:0]         bellek_q [DERINLIK];
    logic [AW-1:0]       yaz_q, yaz_d, oku_q, oku_d;
    logic [AW:0]         sayi_q, sayi_d;
    logic [23:0]         pik_q, pik_d;
    logic [1:0]          sira_q, sira_d;
    logic                pik_v_q, pik_v_d;
    logic [7:0]          bayt_q, bayt_d;
    logic                gecerli_q, gecerli_d, son_q, son_d;
    logic                itme, cek, cikis_bos, bayt_gitti;
`ifdef SONUC_BASLIK_EN
    logic [2:0]          baslik_q, baslik_d;
`endif

    // Stall is a function of registered state only, never of etkin_i.
    always_comb begin
        stal_o = 1'b0;
        if (durum_q == VERI) begin
            stal_o = (sayi_q == DOLU) || (kabul_q == hedef_q);
        end
`ifdef SONUC_BASLIK_EN
        else if (durum_q == BASLIK) begin
            stal_o = 1'b1;
        end
`endif
        else begin
            stal_o = 1'b0;
        end
    end

    assign itme       = (durum_q == VERI) && etkin_i && !stal_o;
    assign cikis_bos  = !gecerli_q || bayt_hazir_i;
    assign bayt_gitti = gecerli_q && bayt_hazir_i;

    // Next state: FIFO, pixel holding stage, byte output stage, counters and run FSM.
    always_comb begin
        durum_d   = durum_q;
        hedef_d   = hedef_q;
        kabul_d   = kabul_q;
        sayac_d   = sayac_q;
        hata_d    = hata_q;
        bitti_d   = 1'b0;
        yaz_d     = yaz_q;
        oku_d     = oku_q;
        sayi_d    = sayi_q;
        pik_d     = pik_q;
        sira_d    = sira_q;
        pik_v_d   = pik_v_q;
        bayt_d    = bayt_q;
        gecerli_d = gecerli_q;
        son_d     = son_q;
        cek       = 1'b0;
`ifdef SONUC_BASLIK_EN
        baslik_d  = baslik_q;
`endif

        // The output register reloads whenever it is empty or its byte leaves this cycle.
        if (cikis_bos) begin
            if (pik_v_q) begin
                case (sira_q)
                    2'd0:    bayt_d = pik_q[23:16];
                    2'd1:    bayt_d = pik_q[15:8];
                    default: bayt_d = pik_q[7:0];
                endcase
                gecerli_d = 1'b1;
                son_d     = (sira_q == 2'd2);
                if (sira_q == 2'd2) begin
                    pik_v_d = 1'b0;
                    sira_d  = 2'd0;
                end else begin
                    sira_d  = sira_q + 2'd1;
                end
            end
`ifdef SONUC_BASLIK_EN
            else if ((durum_q == BASLIK) && (baslik_q != 3'd4)) begin
                bayt_d    = baslik_bayti(baslik_q, 24'(hedef_q));
                gecerli_d = 1'b1;
                son_d     = 1'b0;
                baslik_d  = baslik_q + 3'd1;
            end
`endif
            else begin
                gecerli_d = 1'b0;
                son_d     = 1'b0;
            end
        end else begin
            gecerli_d = gecerli_q;
        end

        // Refill in the same cycle the B byte moves out, so consecutive pixels leave no gap.
        if ((!pik_v_q || (cikis_bos && (sira_q == 2'd2))) && (sayi_q != {(AW+1){1'b0}})) begin
            cek     = 1'b1;
            pik_d   = bellek_q[oku_q];
            sira_d  = 2'd0;
            pik_v_d = 1'b1;
            oku_d   = oku_q + BIR_P;
        end else begin
            cek     = 1'b0;
        end

        if (itme) begin
            yaz_d   = yaz_q + BIR_P;
            kabul_d = kabul_q + BIR_C;
        end else begin
            yaz_d   = yaz_q;
        end

        case ({itme, cek})
            2'b10:   sayi_d = sayi_q + BIR_S;
            2'b01:   sayi_d = sayi_q - BIR_S;
            default: sayi_d = sayi_q;
        endcase

        if (bayt_gitti && son_q) begin
            sayac_d = sayac_q + BIR_C;
        end else begin
            sayac_d = sayac_q;
        end

        case (durum_q)
            BOSTA: begin
                if (basla_i) begin
                    hedef_d = hedef_i;
                    kabul_d = {SAYAC_W{1'b0}};
                    sayac_d = {SAYAC_W{1'b0}};
                    hata_d  = 1'b0;
`ifdef SONUC_BASLIK_EN
                    baslik_d = 3'd0;
                    durum_d  = BASLIK;
`else
                    durum_d  = VERI;
`endif
                end else if (etkin_i) begin
                    hata_d = 1'b1;
                end else begin
                    hata_d = hata_q;
                end
            end
`ifdef SONUC_BASLIK_EN
            BASLIK: begin
                if (bayt_gitti && (baslik_q == 3'd4)) begin
                    durum_d = VERI;
                end else begin
                    durum_d = BASLIK;
                end
            end
`endif
            VERI: begin
                if (sayac_q == hedef_q) begin
                    bitti_d = 1'b1;
                    durum_d = BOSTA;
                end else begin
                    durum_d = VERI;
                end
            end
            default: durum_d = BOSTA;
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            durum_q   <= BOSTA;
            hedef_q   <= {SAYAC_W{1'b0}};
            kabul_q   <= {SAYAC_W{1'b0}};
            sayac_q   <= {SAYAC_W{1'b0}};
            hata_q    <= 1'b0;
            bitti_q   <= 1'b0;
            yaz_q     <= {AW{1'b0}};
            oku_q     <= {AW{1'b0}};
            sayi_q    <= {(AW+1){1'b0}};
            pik_q     <= 24'h000000;
            sira_q    <= 2'd0;
            pik_v_q   <= 1'b0;
            bayt_q    <= 8'h00;
            gecerli_q <= 1'b0;
            son_q     <= 1'b0;
`ifdef SONUC_BASLIK_EN
            baslik_q  <= 3'd0;
`endif
        end else begin
            durum_q   <= durum_d;
            hedef_q   <= hedef_d;
            kabul_q   <= kabul_d;
            sayac_q   <= sayac_d;
            hata_q    <= hata_d;
            bitti_q   <= bitti_d;
            yaz_q     <= yaz_d;
            oku_q     <= oku_d;
            sayi_q    <= sayi_d;
            pik_q     <= pik_d;
            sira_q    <= sira_d;
            pik_v_q   <= pik_v_d;
            bayt_q    <= bayt_d;
            gecerli_q <= gecerli_d;
            son_q     <= son_d;
`ifdef SONUC_BASLIK_EN
            baslik_q  <= baslik_d;
`endif
        end
    end

    // FIFO storage; stale entries are harmless because the pointers are cleared on reset.
    always_ff @(posedge clk_i) begin
        if (itme) begin
            bellek_q[yaz_q] <= pixel_i;
        end
    end

    assign bayt_o         = bayt_q;
    assign bayt_gecerli_o = gecerli_q;
    assign mesgul_o       = (durum_q != BOSTA);
    assign bitti_o        = bitti_q;
    assign hata_o         = hata_q;
    assign sayac_o        = sayac_q;
endmodule

// File: tb/tb_sonuc_toplayici.sv
// Bench for sonuc_toplayici: directed runs with random pixels/handshakes against a byte-queue model.
`timescale 1ns/1ps
module tb_sonuc_toplayici;
    localparam int D = 8;
    localparam int W = 17;
`ifdef SONUC_BASLIK_EN
    localparam int HDR = 4;
`else
    localparam int HDR = 0;
`endif

    logic         clk = 1'b0;
    logic         rst_i, basla_i, etkin_i, bayt_hazir_i;
    logic [W-1:0] hedef_i;
    logic [23:0]  pixel_i;
    logic         stal_o, bayt_gecerli_o, mesgul_o, bitti_o, hata_o;
    logic [7:0]   bayt_o;
    logic [W-1:0] sayac_o;

    sonuc_toplayici #(.DERINLIK(D), .SAYAC_W(W)) dut (
        .clk_i(clk), .rst_i(rst_i), .basla_i(basla_i), .hedef_i(hedef_i),
        .etkin_i(etkin_i), .pixel_i(pixel_i), .stal_o(stal_o), .bayt_o(bayt_o),
        .bayt_gecerli_o(bayt_gecerli_o), .bayt_hazir_i(bayt_hazir_i),
        .mesgul_o(mesgul_o), .bitti_o(bitti_o), .hata_o(hata_o), .sayac_o(sayac_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Reference model: expected byte stream {last_of_pixel, byte} plus run bookkeeping.
    logic [8:0] exp_q[$];
    bit   m_busy = 1'b0, m_hata = 1'b0;
    int   m_tgt = 0, m_acc = 0, m_sent = 0, m_hdr = 0;
    int   etkin_mode = 0, hazir_mode = 0, pix_mode = 0, pix_k = 0, cyc_no = 0;
    int   run_bytes = 0, bitti_cnt = 0, first_byte_cyc = -1, last_byte_cyc = -1;
    bit   hold_v = 1'b0, saw_stal = 1'b0;
    logic [7:0] hold_b = 8'h00;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        bit px_go, by_go, exp_bitti;
        logic [8:0] e;
        int infl;
        case (etkin_mode)
            0: etkin_i = 1'b0;
            1: etkin_i = 1'b1;
            2: etkin_i = ((cyc_no % 3) != 2);
            default: etkin_i = 1'($urandom_range(0, 1));
        endcase
        case (hazir_mode)
            0: bayt_hazir_i = 1'b1;
            1: bayt_hazir_i = ((cyc_no % 4) == 0);
            default: bayt_hazir_i = 1'($urandom_range(0, 1));
        endcase
        #1;
        px_go = etkin_i && !stal_o;
        by_go = bayt_gecerli_o && bayt_hazir_i;
        e = 9'h000;
        if (hold_v) begin
            chk("hold_valid", 32'(bayt_gecerli_o), 32'd1);
            chk("hold_byte", 32'(bayt_o), 32'(hold_b));
        end
        infl = m_acc - m_sent;
        if (!m_busy) chk("stal_idle", 32'(stal_o), 32'd0);
        else if (m_hdr != 0) chk("stal_header", 32'(stal_o), 32'd1);
        else if (m_acc == m_tgt) chk("stal_target", 32'(stal_o), 32'd1);
        else if (infl < D) chk("stal_room", 32'(stal_o), 32'd0);
        else chk("inflight_bound", 32'(infl <= D + 2), 32'd1);
        if (stal_o && m_busy && m_hdr == 0 && m_acc != m_tgt) saw_stal = 1'b1;
        if (by_go) begin
            chk("byte_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("byte_value", 32'(bayt_o), 32'(e[7:0]));
            end
            run_bytes++;
            if (first_byte_cyc < 0) first_byte_cyc = cyc_no;
            last_byte_cyc = cyc_no;
        end
        hold_v = bayt_gecerli_o && !bayt_hazir_i;
        hold_b = bayt_o;
        exp_bitti = 1'b0;
        if (rst_i) begin
            exp_q.delete();
            m_busy = 1'b0; m_hata = 1'b0; m_tgt = 0; m_acc = 0; m_sent = 0; m_hdr = 0;
            hold_v = 1'b0;
        end else if (!m_busy) begin
            if (basla_i) begin
                m_busy = 1'b1; m_tgt = int'(hedef_i); m_acc = 0; m_sent = 0; m_hata = 1'b0;
                m_hdr = HDR;
`ifdef SONUC_BASLIK_EN
                exp_q.push_back(9'h0A5);
                exp_q.push_back({1'b0, 7'b0000000, hedef_i[16]});
                exp_q.push_back({1'b0, hedef_i[15:8]});
                exp_q.push_back({1'b0, hedef_i[7:0]});
`endif
            end else if (etkin_i) begin
                m_hata = 1'b1;
            end
        end else begin
            exp_bitti = (m_hdr == 0) && (m_sent == m_tgt);
            if (px_go && m_hdr == 0 && m_acc < m_tgt) begin
                exp_q.push_back({1'b0, pixel_i[23:16]});
                exp_q.push_back({1'b0, pixel_i[15:8]});
                exp_q.push_back({1'b1, pixel_i[7:0]});
                m_acc++;
            end
            if (by_go && e[8]) m_sent++;
            else if (by_go && m_hdr > 0) m_hdr--;
            if (exp_bitti) m_busy = 1'b0;
        end
        @(posedge clk);
        #1;
        cyc_no++;
        chk("mesgul", 32'(mesgul_o), 32'(m_busy));
        chk("sayac", 32'(sayac_o), 32'(m_sent));
        chk("bitti", 32'(bitti_o), 32'(exp_bitti));
        chk("hata", 32'(hata_o), 32'(m_hata));
        if (bitti_o) bitti_cnt++;
        if (px_go) begin
            pix_k++;
            pixel_i = (pix_mode != 0) ? 24'(pix_k * 17) : 24'($urandom);
        end
    endtask

    task automatic start_run(input int tgt);
        run_bytes = 0; bitti_cnt = 0; first_byte_cyc = -1; last_byte_cyc = -1; saw_stal = 1'b0;
        hedef_i = W'(tgt);
        basla_i = 1'b1;
        cyc();
        basla_i = 1'b0;
    endtask

    task automatic finish_run(input int tgt, input int budget);
        int n;
        n = 0;
        while (m_busy && n < budget) begin
            cyc();
            n++;
        end
        chk("run_ended", 32'(mesgul_o), 32'd0);
        chk("run_bytes", 32'(run_bytes), 32'(3 * tgt + HDR));
        chk("bitti_once", 32'(bitti_cnt), 32'd1);
        chk("sayac_final", 32'(sayac_o), 32'(tgt));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst_i = 1'b1; basla_i = 1'b0; etkin_i = 1'b0; hedef_i = '0; pixel_i = 24'h000000;
        bayt_hazir_i = 1'b1;
        @(posedge clk); #1;
        cyc(); cyc();
        rst_i = 1'b0;
        chk("rst_stal", 32'(stal_o), 32'd0);
        chk("rst_valid", 32'(bayt_gecerli_o), 32'd0);
        chk("rst_bayt", 32'(bayt_o), 32'd0);
        chk("rst_mesgul", 32'(mesgul_o), 32'd0);
        chk("rst_hata", 32'(hata_o), 32'd0);

        // Pixel offered while idle sets the sticky error flag.
        etkin_mode = 1; cyc(); etkin_mode = 0; cyc(); cyc();
        chk("hata_sticky", 32'(hata_o), 32'd1);

        // hedef = 0: bitti with no bytes.
        start_run(0);
        finish_run(0, 30);

        // hedef = 1 with a fixed pixel, latency from acceptance to first valid byte.
        hazir_mode = 0; start_run(1);
        for (int i = 0; i < HDR + 1; i++) cyc();
        pixel_i = 24'h123456; etkin_mode = 1; cyc(); etkin_mode = 0;
        chk("lat_accepted", 32'(m_acc), 32'd1);
        chk("lat_n0", 32'(bayt_gecerli_o), 32'd0);
        cyc();
        chk("lat_n1", 32'(bayt_gecerli_o), 32'd0);
        cyc();
        chk("lat_n2", 32'(bayt_gecerli_o), 32'd1);
        chk("lat_r_byte", 32'(bayt_o), 32'h12);
        finish_run(1, 50);

        // Histogram run, constant ready, continuous input: one byte per cycle.
        pix_mode = 1; pix_k = 0; pixel_i = 24'h000000; etkin_mode = 1; hazir_mode = 0;
        start_run(256);
        finish_run(256, 2000);
        chk("no_bubble_span", 32'(last_byte_cyc - first_byte_cyc), 32'(767 + HDR));

        // Backpressure: ready 1 of every 4 cycles with continuous input.
        pix_mode = 0; pixel_i = 24'($urandom); etkin_mode = 1; hazir_mode = 1;
        start_run(40);
        finish_run(40, 1500);
        chk("saw_full_stall", 32'(saw_stal), 32'd1);

        // Reset in the middle of a long run, then a clean run with random handshakes.
        etkin_mode = 1; hazir_mode = 0;
        start_run(76800);
        n = 0;
        while (m_acc < 100 && n < 1000) begin cyc(); n++; end
        etkin_mode = 0; cyc(); cyc();
        rst_i = 1'b1; cyc(); rst_i = 1'b0;
        chk("midrst_stal", 32'(stal_o), 32'd0);
        chk("midrst_valid", 32'(bayt_gecerli_o), 32'd0);
        chk("midrst_sayac", 32'(sayac_o), 32'd0);
        chk("midrst_mesgul", 32'(mesgul_o), 32'd0);
        etkin_mode = 3; hazir_mode = 2;
        start_run(20);
        finish_run(20, 1000);

        // Producer-like pattern (two pixels, one idle); extra pixels stalled, then error when idle.
        etkin_mode = 2; hazir_mode = 2;
        start_run(200);
        finish_run(200, 3000);
        cyc(); cyc(); cyc();
        chk("hata_after_run", 32'(hata_o), 32'd1);

`ifdef SONUC_BASLIK_EN
        // Header bytes for a full-image target, checked through the byte queue.
        etkin_mode = 1; hazir_mode = 2;
        start_run(76800);
        for (int i = 0; i < 60; i++) cyc();
        chk("hdr_done", 32'(m_hdr), 32'd0);
        rst_i = 1'b1; cyc(); rst_i = 1'b0; etkin_mode = 0; cyc();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
